// File: rtl/ra_pq_p.sv
// Register-array priority queue: sorted cells with the head at cell 0, parallel compare insert, FIFO ties.
// Optional `PQ_STATS_EN adds hwm / ovf_cnt / udf_cnt statistics outputs.
module ra_pq_p #(
    parameter int KEY_W     = 8,
    parameter int VAL_W     = 8,
    parameter int DEPTH     = 16,
    parameter int MAX_FIRST = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enq,
    input  logic                       deq,
    input  logic [KEY_W-1:0]           kvi_key,
    input  logic [VAL_W-1:0]           kvi_val,
    output logic [KEY_W-1:0]           kvo_key,
    output logic [VAL_W-1:0]           kvo_val,
    output logic                       kvo_valid,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
`ifdef PQ_STATS_EN
    output logic [$clog2(DEPTH+1)-1:0] hwm,
    output logic [15:0]                ovf_cnt,
    output logic [15:0]                udf_cnt,
`endif
    output logic                       err_ovf,
    output logic                       err_udf
);
    localparam int CW = $clog2(DEPTH+1);

    function automatic logic precedes(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
        if (MAX_FIRST != 0) return a > b;
        return a < b;
    endfunction

    logic [KEY_W-1:0] key_q [DEPTH];
    logic [KEY_W-1:0] key_d [DEPTH];
    logic [VAL_W-1:0] val_q [DEPTH];
    logic [VAL_W-1:0] val_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             empty_q, full_q, ovf_q, udf_q;
    logic             ovf_d, udf_d;
    logic             do_enq, do_deq;
    // gb[i]: the new entry belongs at or before cell i; gb[DEPTH] stands for the empty slot past the end.
    logic [DEPTH:0]   gb;

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            gb[i] = !vld_q[i] || precedes(kvi_key, key_q[i]);
        gb[DEPTH] = 1'b1;
    end

    assign do_enq = enq && (!full_q || deq);
    assign do_deq = deq && !empty_q;
    assign ovf_d  = enq && !deq && full_q;
    assign udf_d  = deq && empty_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            key_d[i] = key_q[i];
            val_d[i] = val_q[i];
        end
        vld_d = vld_q;
        cnt_d = cnt_q;
        if (do_enq && do_deq) begin
            // Replace: view the array as already shifted down by one, then insert.
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (!gb[i+1]) begin
                    key_d[i] = key_q[i+1];
                    val_d[i] = val_q[i+1];
                    vld_d[i] = vld_q[i+1];
                end else if (i == 0 || !gb[i]) begin
                    key_d[i] = kvi_key;
                    val_d[i] = kvi_val;
                    vld_d[i] = 1'b1;
                end
            end
            if (!gb[DEPTH-1]) begin
                key_d[DEPTH-1] = kvi_key;
                val_d[DEPTH-1] = kvi_val;
                vld_d[DEPTH-1] = 1'b1;
            end
        end else if (do_enq) begin
            if (gb[0]) begin
                key_d[0] = kvi_key;
                val_d[0] = kvi_val;
                vld_d[0] = 1'b1;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (gb[i] && !gb[i-1]) begin
                    key_d[i] = kvi_key;
                    val_d[i] = kvi_val;
                    vld_d[i] = 1'b1;
                end else if (gb[i]) begin
                    key_d[i] = key_q[i-1];
                    val_d[i] = val_q[i-1];
                    vld_d[i] = vld_q[i-1];
                end
            end
            cnt_d = cnt_q + 1'b1;
        end else if (do_deq) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                key_d[i] = key_q[i+1];
                val_d[i] = val_q[i+1];
                vld_d[i] = vld_q[i+1];
            end
            key_d[DEPTH-1] = '0;
            val_d[DEPTH-1] = '0;
            vld_d[DEPTH-1] = 1'b0;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i] <= '0;
                val_q[i] <= '0;
            end
            vld_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i] <= key_d[i];
                val_q[i] <= val_d[i];
            end
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == CW'(DEPTH));
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

`ifdef PQ_STATS_EN
    logic [CW-1:0] hwm_q;
    logic [15:0]   ovf_cnt_q, udf_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hwm_q     <= '0;
            ovf_cnt_q <= '0;
            udf_cnt_q <= '0;
        end else begin
            if (cnt_d > hwm_q) hwm_q <= cnt_d;
            if (ovf_d && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
            if (udf_d && udf_cnt_q != 16'hFFFF) udf_cnt_q <= udf_cnt_q + 16'd1;
        end
    end

    assign hwm     = hwm_q;
    assign ovf_cnt = ovf_cnt_q;
    assign udf_cnt = udf_cnt_q;
`endif

    assign kvo_key   = key_q[0];
    assign kvo_val   = val_q[0];
    assign kvo_valid = vld_q[0];
    assign empty     = empty_q;
    assign full      = full_q;
    assign count     = cnt_q;
    assign err_ovf   = ovf_q;
    assign err_udf   = udf_q;
endmodule

// File: tb/tb_ra_pq_p.sv
// Directed bench for ra_pq_p: a min-first and a max-first instance (DEPTH=4) share one stimulus stream.
module tb_ra_pq_p;
    logic       clk = 1'b0;
    logic       rst_n, enq, deq;
    logic [7:0] kvi_key, kvi_val;

    logic [7:0] a_key, a_val, b_key, b_val;
    logic       a_vld, a_emp, a_full, a_ovf, a_udf;
    logic       b_vld, b_emp, b_full, b_ovf, b_udf;
    logic [2:0] a_cnt, b_cnt;
`ifdef PQ_STATS_EN
    logic [2:0]  a_hwm, b_hwm;
    logic [15:0] a_oc, a_uc, b_oc, b_uc;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ra_pq_p #(.KEY_W(8), .VAL_W(8), .DEPTH(4), .MAX_FIRST(0)) u_min (
        .clk(clk), .rst_n(rst_n), .enq(enq), .deq(deq),
        .kvi_key(kvi_key), .kvi_val(kvi_val),
        .kvo_key(a_key), .kvo_val(a_val), .kvo_valid(a_vld),
        .empty(a_emp), .full(a_full), .count(a_cnt),
`ifdef PQ_STATS_EN
        .hwm(a_hwm), .ovf_cnt(a_oc), .udf_cnt(a_uc),
`endif
        .err_ovf(a_ovf), .err_udf(a_udf)
    );

    ra_pq_p #(.KEY_W(8), .VAL_W(8), .DEPTH(4), .MAX_FIRST(1)) u_max (
        .clk(clk), .rst_n(rst_n), .enq(enq), .deq(deq),
        .kvi_key(kvi_key), .kvi_val(kvi_val),
        .kvo_key(b_key), .kvo_val(b_val), .kvo_valid(b_vld),
        .empty(b_emp), .full(b_full), .count(b_cnt),
`ifdef PQ_STATS_EN
        .hwm(b_hwm), .ovf_cnt(b_oc), .udf_cnt(b_uc),
`endif
        .err_ovf(b_ovf), .err_udf(b_udf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock with the given request; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic e, input logic d, input logic [7:0] k, input logic [7:0] v);
        enq = e; deq = d; kvi_key = k; kvi_val = v;
        @(posedge clk);
        #1;
        enq = 1'b0; deq = 1'b0;
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, ".empty"}, a_emp, 1);
        chk({tag, ".full"},  a_full, 0);
        chk({tag, ".count"}, a_cnt, 0);
        chk({tag, ".valid"}, a_vld, 0);
        chk({tag, ".key"},   a_key, 0);
        chk({tag, ".ovf"},   a_ovf, 0);
        chk({tag, ".udf"},   a_udf, 0);
    endtask

    initial begin
        rst_n = 1'b0; enq = 1'b0; deq = 1'b0; kvi_key = '0; kvi_val = '0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        rst_n = 1'b1;
        repeat (3) cyc(0, 0, 0, 0);
        chk_a_reset("rst");
        chk("rst.b_empty", b_emp, 1);

        // Ordering and FIFO ties, min-first
        cyc(1, 0, 5, 1); chk("o1.ovf", a_ovf, 0);
        cyc(1, 0, 3, 2); chk("o2.head", a_key, 3);
        cyc(1, 0, 9, 3); chk("o3.ovf", a_ovf, 0);
        cyc(1, 0, 3, 4);
        chk("o4.key", a_key, 3); chk("o4.val", a_val, 2);
        chk("o4.count", a_cnt, 4); chk("o4.full", a_full, 1);
        cyc(0, 1, 0, 0); chk("d1.key", a_key, 3); chk("d1.val", a_val, 4);
        cyc(0, 1, 0, 0); chk("d2.key", a_key, 5); chk("d2.val", a_val, 1);
        cyc(0, 1, 0, 0); chk("d3.key", a_key, 9); chk("d3.val", a_val, 3);
        chk("d3.udf", a_udf, 0);
        cyc(0, 1, 0, 0);
        chk("d4.empty", a_emp, 1); chk("d4.valid", a_vld, 0);
        chk("d4.key", a_key, 0); chk("d4.udf", a_udf, 0);

        // Overflow on a full queue
        cyc(1, 0, 1, 10); cyc(1, 0, 2, 11); cyc(1, 0, 3, 12); cyc(1, 0, 4, 13);
        chk("f.ovf_pre", a_ovf, 0);
        cyc(1, 0, 0, 99);
        chk("f.ovf", a_ovf, 1); chk("f.full", a_full, 1);
        chk("f.head", a_key, 1); chk("f.count", a_cnt, 4);
        cyc(0, 0, 0, 0); chk("f.ovf_clr", a_ovf, 0);

        // Replace on a full queue
        cyc(1, 1, 0, 20);
        chk("r.head", a_key, 0); chk("r.val", a_val, 20);
        chk("r.count", a_cnt, 4); chk("r.ovf", a_ovf, 0);
        cyc(0, 1, 0, 0); chk("r.d1", a_key, 2); chk("r.d1cnt", a_cnt, 3);
        cyc(0, 1, 0, 0); chk("r.d2", a_key, 3);
        cyc(0, 1, 0, 0); chk("r.d3", a_key, 4);
        cyc(0, 1, 0, 0); chk("r.empty", a_emp, 1);

        // Underflow, and enq+deq on an empty queue
        cyc(0, 1, 0, 0); chk("u.udf", a_udf, 1); chk("u.count", a_cnt, 0);
        cyc(0, 0, 0, 0); chk("u.udf_clr", a_udf, 0);
        cyc(1, 1, 7, 5);
        chk("u.count1", a_cnt, 1); chk("u.head", a_key, 7);
        chk("u.udf2", a_udf, 1); chk("u.valid", a_vld, 1);
        cyc(0, 1, 0, 0); chk("u.drain", a_emp, 1);

        // Max-first, reset during an enqueue, then refill
        cyc(1, 0, 2, 1); cyc(1, 0, 8, 2); cyc(1, 0, 5, 3);
        chk("m.head_pre", b_key, 8);
        rst_n = 1'b0;
        cyc(1, 0, 6, 4);
        rst_n = 1'b1;
        chk("mr.empty", b_emp, 1); chk("mr.count", b_cnt, 0);
        chk("mr.valid", b_vld, 0); chk("mr.key", b_key, 0);
        chk("mr.full", b_full, 0); chk("mr.ovf", b_ovf, 0); chk("mr.udf", b_udf, 0);
        cyc(1, 0, 2, 1); cyc(1, 0, 8, 2); cyc(1, 0, 5, 3);
        chk("m.head8", b_key, 8); chk("m.val8", b_val, 2); chk("m.count", b_cnt, 3);
`ifdef PQ_STATS_EN
        chk("m.hwm", b_hwm, 3);
`endif
        cyc(0, 1, 0, 0); chk("m.head5", b_key, 5);
        cyc(0, 1, 0, 0); chk("m.head2", b_key, 2);
        cyc(0, 1, 0, 0); chk("m.empty", b_emp, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ra_pq_p.md
Name: ra_pq_p

Overview:
- Parametrised register-array priority queue: the next generation of the ra_pq_s-style queue.
- Generalised in key width, value width and depth; min-first or max-first ordering selected by parameter.
- Adds same-cycle replace (enqueue plus dequeue), FIFO tie-breaking, occupancy count and overflow/underflow error flags.
- Device side of the pq_rd_if-style queue harness; holds a sorted array with the head entry always presented at the output.

Parameters:
- KEY_W, 8, key (priority) width in bits.
- VAL_W, 8, payload width in bits.
- DEPTH, 16, number of entries; must be at least 2.
- MAX_FIRST, 0, 0 = smallest key is head; 1 = largest key is head.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- enq  in  1  insert kvi_key/kvi_val this cycle.
- deq  in  1  remove the head entry this cycle.
- kvi_key  in  KEY_W  key to insert.
- kvi_val  in  VAL_W  payload to insert.
- kvo_key  out  KEY_W  head key; 0 when empty.
- kvo_val  out  VAL_W  head payload; 0 when empty.
- kvo_valid  out  1  head valid; equals !empty.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH+1)  occupancy.
- err_ovf  out  1  one-cycle pulse: enq rejected because the queue was full.
- err_udf  out  1  one-cycle pulse: deq with the queue empty.

Behaviour:
- Reset (rst_n low at a clk edge): all cells invalid, key/val storage cleared to 0, count 0, empty 1, full 0, kvo_* 0, err_* 0. Reset overrides enq/deq in the same cycle; reset mid-operation discards all contents.
- Storage: cells 0..DEPTH-1, each holding {valid, key, val}, kept sorted at all times. Cell 0 is the head; valid cells are contiguous from 0.
- Ordering: "a precedes b" means a.key < b.key when MAX_FIRST=0, and a.key > b.key when MAX_FIRST=1.
- Ties: equal keys leave in insertion order (FIFO). A new entry is placed after all existing entries with an equal key.
- kvo_*, empty, full and count are driven directly from registers; no combinational path from enq/deq/kvi_* to any output.
- Latency: an operation issued in cycle N is visible at the outputs in cycle N+1, so one operation per cycle is sustained.
- enq only, not full:
  - insertion index p = number of valid entries that do not follow the new key;
  - cells p..count-1 shift to p+1..count; cell p takes the new entry; count+1.
- enq only, full: queue unchanged; err_ovf=1 for one cycle.
- deq only, not empty: cells 1..count-1 shift to 0..count-2; cell count-1 is invalidated and zeroed; count-1.
- deq only, empty: queue unchanged; err_udf=1 for one cycle.
- enq and deq together, not empty (replace):
  - head removed and new entry inserted into the remaining count-1 entries in one cycle; count unchanged;
  - legal when full, and no err_ovf is raised.
- enq and deq together, empty: enq performed (count becomes 1); err_udf=1 for one cycle.
- Neither enq nor deq: state holds; err_* are 0.
- Compare network: each cell evaluates (new precedes cell) or (cell is invalid) in parallel. There is no iterative search and no busy state.

Optional Feature:
- Macro: PQ_STATS_EN.
- Defined: adds output hwm, width $clog2(DEPTH+1), holding the maximum count reached since reset. Also adds outputs ovf_cnt and udf_cnt, 16 bits each, counting err_ovf and err_udf pulses and saturating at 0xFFFF. All three reset to 0 with rst_n.
- Not defined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then idle 3 cycles: empty=1, full=0, count=0, kvo_valid=0, kvo_key=0, err_ovf=0, err_udf=0.
- MAX_FIRST=0, enq keys 5,3,9,3 (vals 1,2,3,4), then 4 deqs: heads out are (3,2),(3,4),(5,1),(9,3); empty=1 after the 4th deq; no err pulses.
- DEPTH=4: enq keys 1,2,3,4, then enq key 0: full=1, err_ovf=1 for one cycle, head stays key 1, count=4.
- Full queue {1,2,3,4}, enq key 0 together with deq: head becomes key 0, count=4, no err_ovf. Next deq-only yields key 0, then key 2.
- Empty queue, deq: err_udf=1 for one cycle, count=0. Empty queue, enq key 7 with deq: count=1, head key 7, err_udf=1.
- MAX_FIRST=1, enq keys 2,8,5, assert rst_n=0 during the 4th enq: all outputs at reset values the next cycle. Refill with 2,8,5: heads out 8,5,2. With PQ_STATS_EN defined, hwm=3.
